// File: rtl/life_pkg.sv
// Shared types and constants for the Game-of-Life row engine.
// Holds the sequencer state enum, the B3/S23 rule constants and the
// generation counter width.
package life_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    SWAP  = 2'd3
  } state_t;

  // B3/S23: a dead cell with exactly 3 live neighbours is born, a live
  // cell with 2 or 3 live neighbours survives.
  localparam logic [3:0] BIRTH_N    = 4'd3;
  localparam logic [3:0] SURVIVE_LO = 4'd2;
  localparam logic [3:0] SURVIVE_HI = 4'd3;

  localparam int GEN_W = 16;

endpackage

// File: rtl/life_row_engine_if.sv
// Row bus between the life engine and the ping-pong line store:
// a read port (address out, data back one cycle later) and a write port.
interface life_row_engine_if #(
  parameter int X_SIZE  = 1280,
  parameter int Y_WIDTH = 10
);
  logic [Y_WIDTH-1:0] fetch_addr;
  logic [X_SIZE-1:0]  fetch_data;
  logic [Y_WIDTH-1:0] wr_addr;
  logic [X_SIZE-1:0]  wr_data;
  logic               wr_en;

  modport master (
    output fetch_addr,
    input  fetch_data,
    output wr_addr,
    output wr_data,
    output wr_en
  );

  modport slave (
    input  fetch_addr,
    output fetch_data,
    input  wr_addr,
    input  wr_data,
    input  wr_en
  );
endinterface

// File: rtl/life_cell_rule.sv
// One-cell B3/S23 next-state function: current cell plus its 8 neighbours.
module life_cell_rule
  import life_pkg::*;
(
  input  logic       cur,
  input  logic [7:0] nbrs,
  output logic       nxt
);
  logic [3:0] cnt;

  // Population count of the neighbourhood, then apply birth/survive rule
  always_comb begin
    cnt = '0;
    for (int i = 0; i < 8; i++) cnt = cnt + {3'b000, nbrs[i]};
    nxt = cur ? ((cnt >= SURVIVE_LO) && (cnt <= SURVIVE_HI)) : (cnt == BIRTH_N);
  end
endmodule

// File: rtl/life_row_engine.sv
// Game-of-Life generation engine: streams Y_SIZE+2 rows through a 3-row
// window and writes one next-state row per cycle.
// Optional feature macro: TOROIDAL_EN -- wrap rows and columns; when
// undefined, everything outside the frame reads as dead.
module life_row_engine
  import life_pkg::*;
#(
  parameter int X_SIZE  = 1280,
  parameter int Y_SIZE  = 720,
  parameter int X_WIDTH = 11,
  parameter int Y_WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             pause,
  output logic             buffer_sel,
  output logic             busy,
  output logic             gen_done,
  output logic [GEN_W-1:0] gen_count,
  life_row_engine_if.master bus
);
  // fetch index reaches Y_SIZE+1, so one bit wider than a row index
  localparam logic [Y_WIDTH:0]   FETCH_LAST = (Y_WIDTH+1)'(Y_SIZE + 1);
  localparam logic [Y_WIDTH-1:0] ROW_LAST   = Y_WIDTH'(Y_SIZE - 1);
  localparam int                 STAGES     = 2;

  state_t               state, state_nxt;
  logic [Y_WIDTH:0]     fcnt;
  logic [1:0]           dcnt;
  // [0]: data for a write-eligible fetch returns, [1]: window holds it,
  // [2]: next-state row registered on the write port
  logic [STAGES:0]      vld_pipe;
  logic                 shift_q;
  logic [X_SIZE-1:0]    top, mid, bot, nxt_row;
`ifndef TOROIDAL_EN
  logic                 pad_q;
`endif

  assign busy      = (state != IDLE);
  assign bus.wr_en = vld_pipe[STAGES];

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Sequencer next-state: pause blocks a new start but never a running one
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !pause) state_nxt = FETCH;
      FETCH:   if (fcnt == FETCH_LAST) state_nxt = DRAIN;
      DRAIN:   if (dcnt == 2'd2) state_nxt = SWAP;
      SWAP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Fetch/drain counters and the wrapped read-row address
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fcnt           <= '0;
      dcnt           <= '0;
      bus.fetch_addr <= '0;
    end else begin
      case (state)
        IDLE: if (state_nxt == FETCH) begin
          fcnt           <= '0;
          bus.fetch_addr <= ROW_LAST;
        end
        FETCH: begin
          fcnt <= fcnt + 1'b1;
          dcnt <= '0;
          if (fcnt != FETCH_LAST)
            bus.fetch_addr <= (bus.fetch_addr == ROW_LAST) ? '0 : bus.fetch_addr + 1'b1;
        end
        DRAIN:   dcnt <= dcnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Row window, valid pipeline and registered write port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe    <= '0;
      shift_q     <= 1'b0;
`ifndef TOROIDAL_EN
      pad_q       <= 1'b0;
`endif
      top         <= '0;
      mid         <= '0;
      bot         <= '0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], (state == FETCH) && (fcnt >= 2)};
      shift_q  <= (state == FETCH);
`ifndef TOROIDAL_EN
      // the two halo fetches still take their slot but load dead rows
      pad_q    <= (state == FETCH) && ((fcnt == '0) || (fcnt == FETCH_LAST));
`endif
      if (shift_q) begin
        top <= mid;
        mid <= bot;
`ifdef TOROIDAL_EN
        bot <= bus.fetch_data;
`else
        bot <= pad_q ? '0 : bus.fetch_data;
`endif
      end
      if (vld_pipe[STAGES-1]) begin
        bus.wr_data <= nxt_row;
        bus.wr_addr <= vld_pipe[STAGES] ? bus.wr_addr + 1'b1 : '0;
      end
    end
  end

  // Generation completion: pulse, buffer flip and count land together in SWAP
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gen_done   <= 1'b0;
      buffer_sel <= 1'b0;
      gen_count  <= '0;
    end else begin
      gen_done <= (state == DRAIN) && (state_nxt == SWAP);
      if ((state == DRAIN) && (state_nxt == SWAP)) begin
        buffer_sel <= ~buffer_sel;
        gen_count  <= gen_count + 1'b1;
      end
    end
  end

  // One rule cell per column; column c is bit c of every row
  for (genvar c = 0; c < X_SIZE; c++) begin : g_col
    localparam logic [X_WIDTH-1:0] CL = X_WIDTH'((c + X_SIZE - 1) % X_SIZE);
    localparam logic [X_WIDTH-1:0] CR = X_WIDTH'((c + 1) % X_SIZE);
    logic [7:0] nbrs;
`ifdef TOROIDAL_EN
    assign nbrs = {top[CL], top[c], top[CR], mid[CL], mid[CR], bot[CL], bot[c], bot[CR]};
`else
    localparam logic HAS_L = (c != 0);
    localparam logic HAS_R = (c != X_SIZE - 1);
    assign nbrs = {top[CL] & HAS_L, top[c], top[CR] & HAS_R,
                   mid[CL] & HAS_L,         mid[CR] & HAS_R,
                   bot[CL] & HAS_L, bot[c], bot[CR] & HAS_R};
`endif
    life_cell_rule u_rule (
      .cur  (mid[c]),
      .nbrs (nbrs),
      .nxt  (nxt_row[c])
    );
  end
endmodule

// File: tb/tb_life_row_engine.sv
// Self-checking bench for life_row_engine (X_SIZE=8, Y_SIZE=6).
// Expected rows are queued when a generation is started and compared,
// with their write cycle, as the engine writes them.
module tb_life_row_engine;
  localparam int XS = 8;
  localparam int YS = 6;
  localparam int XW = 3;
  localparam int YW = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        buffer_sel, busy, gen_done;
  logic [15:0] gen_count;

  always #5 clk = ~clk;

  life_row_engine_if #(.X_SIZE(XS), .Y_WIDTH(YW)) bus ();

  life_row_engine #(.X_SIZE(XS), .Y_SIZE(YS), .X_WIDTH(XW), .Y_WIDTH(YW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pause      (pause),
    .buffer_sel (buffer_sel),
    .busy       (busy),
    .gen_done   (gen_done),
    .gen_count  (gen_count),
    .bus        (bus)
  );

  // source frame and its one-cycle-latency read port
  logic [XS-1:0] src [YS];
  logic [XS-1:0] exp_rows [YS];
  always @(posedge clk) bus.fetch_data <= (int'(bus.fetch_addr) < YS) ? src[bus.fetch_addr] : '0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_gc = 0;
  bit exp_bs = 1'b0;
  bit sb_on = 1'b1;

  typedef struct {
    int            row;
    logic [XS-1:0] data;
    int            cyc;
  } wr_exp_t;
  wr_exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // write-port monitor: every strobe must match the head of the scoreboard
  always @(negedge clk) begin
    wr_exp_t e;
    if (sb_on && bus.wr_en === 1'b1) begin
      if (sb.size() == 0) chk("wr_unexpected", 32'(bus.wr_en), 0);
      else begin
        e = sb.pop_front();
        chk("wr_addr", 32'(bus.wr_addr), e.row);
        chk("wr_data", 32'(bus.wr_data), 32'(e.data));
        chk("wr_cycle", cyc, e.cyc);
      end
    end
  end

  // reference next-state of row r from the source frame
  function automatic logic [XS-1:0] model_row(input int r);
    logic [XS-1:0] res;
    int n, rr, cc;
    res = '0;
    for (int c = 0; c < XS; c++) begin
      n = 0;
      for (int dr = -1; dr <= 1; dr++)
        for (int dc = -1; dc <= 1; dc++)
          if (dr != 0 || dc != 0) begin
            rr = r + dr;
            cc = c + dc;
`ifdef TOROIDAL_EN
            rr = (rr + YS) % YS;
            cc = (cc + XS) % XS;
            n += int'(src[rr][cc]);
`else
            if (rr >= 0 && rr < YS && cc >= 0 && cc < XS) n += int'(src[rr][cc]);
`endif
          end
      res[c] = src[r][c] ? (n == 2 || n == 3) : (n == 3);
    end
    return res;
  endfunction

  task automatic clear_src();
    for (int r = 0; r < YS; r++) src[r] = '0;
  endtask

  task automatic fill_model();
    for (int r = 0; r < YS; r++) exp_rows[r] = model_row(r);
  endtask

  // start one generation; pause_at/rst_at are cycle offsets from s (<0: unused)
  task automatic run_gen(input int pause_at, input int rst_at);
    int s, ndone;
    wr_exp_t e;
    ndone = 0;
    @(negedge clk);
    s = cyc;
    for (int r = 0; r < YS; r++)
      if (rst_at < 0 || r + 6 <= rst_at) begin
        e.row = r; e.data = exp_rows[r]; e.cyc = s + r + 6;
        sb.push_back(e);
      end
    start = 1'b1;
    for (int i = 1; i <= YS + 10; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == pause_at) pause = 1'b1;
      if (i == rst_at) rst_n = 1'b0;
      if (rst_at >= 0 && i == rst_at + 1) begin
        rst_n = 1'b1;
        exp_gc = 0;
        exp_bs = 1'b0;
        chk("rst_wr_en", 32'(bus.wr_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_buffer_sel", 32'(buffer_sel), 0);
        chk("rst_gen_count", 32'(gen_count), 0);
      end
      if (gen_done === 1'b1) begin
        ndone++;
        chk("gen_done_cycle", cyc, s + YS + 6);
      end
    end
    pause = 1'b0;
    if (rst_at < 0) begin
      exp_gc = (exp_gc + 1) & 16'hFFFF;
      exp_bs = ~exp_bs;
    end
    chk("gen_done_count", ndone, (rst_at < 0) ? 1 : 0);
    chk("gen_count", 32'(gen_count), exp_gc);
    chk("buffer_sel", 32'(buffer_sel), 32'(exp_bs));
    chk("busy_after", 32'(busy), 0);
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    int np, budget;
    clear_src();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_wr_en", 32'(bus.wr_en), 0);
    chk("reset_gen_done", 32'(gen_done), 0);
    chk("reset_buffer_sel", 32'(buffer_sel), 0);
    chk("reset_gen_count", 32'(gen_count), 0);
    chk("reset_fetch_addr", 32'(bus.fetch_addr), 0);
    chk("reset_wr_addr", 32'(bus.wr_addr), 0);
    chk("reset_wr_data", 32'(bus.wr_data), 0);
    rst_n = 1'b1;

    // blinker: vertical bar at column 3 becomes horizontal on row 2
    clear_src();
    src[1][3] = 1'b1; src[2][3] = 1'b1; src[3][3] = 1'b1;
    for (int r = 0; r < YS; r++) exp_rows[r] = '0;
    exp_rows[2] = 8'b0001_1100;
    run_gen(-1, -1);
    // idle: ports hold the last generation's final values
    chk("idle_wr_addr", 32'(bus.wr_addr), YS - 1);
    chk("idle_fetch_addr", 32'(bus.fetch_addr), 0);
    chk("idle_wr_data", 32'(bus.wr_data), 0);

    // block still life in the corner: frame reproduces itself
    clear_src();
    src[0][0] = 1'b1; src[0][1] = 1'b1; src[1][0] = 1'b1; src[1][1] = 1'b1;
    for (int r = 0; r < YS; r++) exp_rows[r] = src[r];
    run_gen(-1, -1);

    // three corner cells: a birth at (5,7) only across the wrap
    clear_src();
    src[0][0] = 1'b1; src[0][7] = 1'b1; src[5][0] = 1'b1;
    for (int r = 0; r < YS; r++) exp_rows[r] = '0;
`ifdef TOROIDAL_EN
    exp_rows[0] = 8'b1000_0001;
    exp_rows[5] = 8'b1000_0001;
`endif
    run_gen(-1, -1);

    // random frames against the reference model
    for (int t = 0; t < 3; t++) begin
      for (int r = 0; r < YS; r++) src[r] = 8'($urandom);
      fill_model();
      run_gen(-1, -1);
    end

    // pause wins over start: nothing starts
    @(negedge clk);
    pause = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("paused_busy", 32'(busy), 0);
    end
    chk("paused_fetch_addr", 32'(bus.fetch_addr), 0);
    pause = 1'b0;

    // pause raised mid-generation does not stop it
    for (int r = 0; r < YS; r++) src[r] = 8'($urandom);
    fill_model();
    run_gen(3, -1);

    // reset at s+8 aborts after rows 0..2, then a clean generation
    run_gen(-1, 8);
    fill_model();
    run_gen(-1, -1);

    // full 16-bit wrap of gen_count with start held high
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_src();
    sb_on = 1'b0;
    start = 1'b1;
    np = 0;
    budget = 0;
    while (np < 65536 && budget < 1000000) begin
      @(negedge clk);
      budget++;
      if (gen_done === 1'b1) begin
        np++;
        if (np == 65535) begin
          chk("wrap_pre_count", 32'(gen_count), 32'hFFFF);
          chk("wrap_pre_bsel", 32'(buffer_sel), 1);
        end
        if (np == 65536) start = 1'b0;
      end
    end
    start = 1'b0;
    chk("wrap_gens", np, 65536);
    repeat (2) @(negedge clk);
    chk("wrap_gen_count", 32'(gen_count), 0);
    chk("wrap_buffer_sel", 32'(buffer_sel), 0);
    chk("wrap_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
